// File: rtl/ofdm_ml_pkg.sv
// Shared definitions for the ML preamble correlator: coefficient codes and
// output width derivation.
package ofdm_ml_pkg;

    localparam logic [1:0] ML_ZERO = 2'b00;
    localparam logic [1:0] ML_HALF = 2'b01;
    localparam logic [1:0] ML_ONE  = 2'b10;
    localparam logic [1:0] ML_NEG  = 2'b11;

    function automatic int ml_clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Correlation width: sample, one bit for the negated minimum, one per tree level.
    function automatic int ml_ow(input int width, input int taps);
        return width + 1 + ml_clog2(taps);
    endfunction

endpackage

// File: rtl/ml_tap_weight.sv
// One correlator tap: applies a 2-bit preamble code to a sample, producing a
// sign-extended product one bit wider than the sample.
module ml_tap_weight
    import ofdm_ml_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic [1:0]              code,
    input  logic signed [WIDTH-1:0] sample,
    output logic signed [WIDTH:0]   prod
);

    logic signed [WIDTH:0] ext;

    assign ext = {sample[WIDTH-1], sample};

    // The extra bit lets the most negative sample negate without overflow.
    always_comb begin
        prod = '0;
        case (code)
            ML_HALF: prod = ext >>> 1;
            ML_ONE:  prod = ext;
            ML_NEG:  prod = -ext;
            default: prod = '0;
        endcase
    end

endmodule

// File: rtl/ml_corr_bank.sv
// Pipelined matched-filter correlator with running peak tracker, used for
// preamble timing synchronisation.
module ml_corr_bank
    import ofdm_ml_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int TAPS  = 16,
    parameter int IDXW  = 16
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic signed [WIDTH-1:0]                 din,
    input  logic                                    din_valid,
    input  logic                                    coeff_we,
    input  logic [ml_clog2(TAPS)-1:0]               coeff_addr,
    input  logic [1:0]                              coeff_data,
    input  logic                                    clear,
    input  logic [ml_ow(WIDTH, TAPS)-2:0]           thr,
    output logic signed [ml_ow(WIDTH, TAPS)-1:0]    dout,
    output logic                                    dout_valid,
    output logic                                    peak_flag,
    output logic [IDXW-1:0]                         peak_idx
);

    localparam int LOG = ml_clog2(TAPS);
    localparam int OW  = ml_ow(WIDTH, TAPS);
    localparam int MW  = OW - 1;
    localparam int PW  = WIDTH + 1;
    localparam int FW  = LOG + 1;

    logic [1:0]              coeff    [TAPS];
    logic signed [WIDTH-1:0] dline    [TAPS];
    logic signed [PW-1:0]    prod     [TAPS];
    logic signed [OW-1:0]    prod_r   [TAPS];
    logic                    v_pipe   [LOG];
    logic [IDXW-1:0]         idx_pipe [LOG];

    logic [FW-1:0]        fill;
    logic [IDXW-1:0]      idx_cnt;
    logic                 win_v;
    logic [IDXW-1:0]      win_idx;
    logic                 accept;
    logic signed [OW-1:0] fin_a;
    logic signed [OW-1:0] fin_b;
    logic signed [OW-1:0] sum_fin;
    logic [MW-1:0]        mag;
    logic [MW-1:0]        max_mag;
    logic                 new_peak;

    assign accept = din_valid & ~clear;

    // Coefficients survive clear; only RST returns them to zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < TAPS; i++) coeff[i] <= ML_ZERO;
        end else if (coeff_we) begin
            coeff[coeff_addr] <= coeff_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            for (int i = 0; i < TAPS; i++) dline[i] <= '0;
            fill    <= '0;
            idx_cnt <= '0;
            win_v   <= 1'b0;
            win_idx <= '0;
        end else begin
            win_v   <= accept && (fill >= FW'(TAPS - 1));
            win_idx <= idx_cnt;
            if (accept) begin
                dline[0] <= din;
                for (int i = 1; i < TAPS; i++) dline[i] <= dline[i-1];
                idx_cnt <= idx_cnt + 1'b1;
                if (fill != FW'(TAPS)) fill <= fill + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < TAPS; g++) begin : g_tap
        ml_tap_weight #(.WIDTH(WIDTH)) u_weight (
            .code   (coeff[g]),
            .sample (dline[g]),
            .prod   (prod[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < TAPS; i++) prod_r[i] <= '0;
        end else begin
            for (int i = 0; i < TAPS; i++) prod_r[i] <= {{(OW-PW){prod[i][PW-1]}}, prod[i]};
        end
    end

    // Valid and index travel beside the data: stage 0 is weighting, stage k is tree level k-1.
    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            for (int k = 0; k < LOG; k++) begin
                v_pipe[k]   <= 1'b0;
                idx_pipe[k] <= '0;
            end
        end else begin
            v_pipe[0]   <= win_v;
            idx_pipe[0] <= win_idx;
            for (int k = 1; k < LOG; k++) begin
                v_pipe[k]   <= v_pipe[k-1];
                idx_pipe[k] <= idx_pipe[k-1];
            end
        end
    end

    // All but the last tree level; the last one is the dout register itself.
    for (genvar l = 0; l < LOG - 1; l++) begin : g_lvl
        localparam int N = TAPS >> (l + 1);
        logic signed [OW-1:0] s [N];
        if (l == 0) begin : g_first
            always_ff @(posedge CLK) begin
                if (RST) begin
                    for (int j = 0; j < N; j++) s[j] <= '0;
                end else begin
                    for (int j = 0; j < N; j++) s[j] <= prod_r[2*j] + prod_r[2*j+1];
                end
            end
        end else begin : g_next
            always_ff @(posedge CLK) begin
                if (RST) begin
                    for (int j = 0; j < N; j++) s[j] <= '0;
                end else begin
                    for (int j = 0; j < N; j++) s[j] <= g_lvl[l-1].s[2*j] + g_lvl[l-1].s[2*j+1];
                end
            end
        end
    end

    if (LOG == 1) begin : g_fin_direct
        assign fin_a = prod_r[0];
        assign fin_b = prod_r[1];
    end else begin : g_fin_tree
        assign fin_a = g_lvl[LOG-2].s[0];
        assign fin_b = g_lvl[LOG-2].s[1];
    end

    // |sum| never exceeds TAPS * 2^(WIDTH-1), so it fits in OW-1 unsigned bits.
    assign sum_fin  = fin_a + fin_b;
    assign mag      = sum_fin[OW-1] ? MW'(-sum_fin) : MW'(sum_fin);
    assign new_peak = v_pipe[LOG-1] && (mag >= thr) && (mag > max_mag);

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            peak_flag  <= 1'b0;
            peak_idx   <= '0;
            max_mag    <= '0;
        end else begin
            dout_valid <= v_pipe[LOG-1];
            peak_flag  <= new_peak;
            if (v_pipe[LOG-1]) dout <= sum_fin;
            if (new_peak) begin
                max_mag  <= mag;
                peak_idx <= idx_pipe[LOG-1];
            end
        end
    end

endmodule

// File: doc/ml_corr_bank.md
# ml_corr_bank

Parametrised, pipelined matched-filter correlator for preamble timing synchronisation in the 802.16 OFDM receiver. Per-tap 2-bit known-preamble codes (zero, half, one, minus one) weight a sliding window of received metric samples. The block sums the weighted window through a registered adder tree and tracks the running correlation peak, reporting its sample index. It sits between the ML metric generator and the frame-timing controller.

## Interface

Parameters:
- `WIDTH`, 17: signed input sample width.
- `TAPS`, 16: window length. Must be a power of two, ≥2.
- `IDXW`, 16: sample-index counter width.

Ports (clock and reset first):
- `CLK`  in  1: the only clock.
- `RST`  in  1: reset, synchronous, active-high.
- `din`  in  WIDTH: signed sample.
- `din_valid`  in  1: sample strobe. No backpressure.
- `coeff_we`  in  1: coefficient write strobe.
- `coeff_addr`  in  clog2(TAPS): tap index. Tap 0 weights the newest sample.
- `coeff_data`  in  2: code. 00 = 0, 01 = ×0.5, 10 = ×1, 11 = ×(−1).
- `clear`  in  1: flush window, pipeline and peak tracker. Coefficients are kept.
- `thr`  in  OW−1: unsigned peak threshold.
- `dout`  out  OW: signed correlation, where OW = WIDTH + 1 + clog2(TAPS).
- `dout_valid`  out  1: `dout` strobe.
- `peak_flag`  out  1: one-cycle pulse when a new peak is found.
- `peak_idx`  out  IDXW: index of the sample that completed the peak window.

## Operation

- **Delay line.** On `din_valid`, samples shift: tap0 ← `din`, tapk ← tap(k−1). Without `din_valid` the line holds.
- **Sample index.** The index counter increments per accepted sample, starting at 0 after reset or clear, and wraps modulo 2^IDXW.
- **Fill counter.** Counts accepted samples and saturates at TAPS. No result is produced until the window is full: the first `dout_valid` corresponds to sample index TAPS−1.
- **Tap weighting.** Each tap product is WIDTH+1 bits, sign-extended:
  - code 00 → 0.
  - code 01 → arithmetic shift right by 1 (rounds toward −∞).
  - code 10 → sample.
  - code 11 → two's-complement negation. −2^(WIDTH−1) maps to +2^(WIDTH−1) with no overflow.
- **Adder tree.** Registered, binary, clog2(TAPS) levels. Each level widens by 1 bit. The sum is exact and never saturates.
- **Coefficients.**
  - Written on `coeff_we`; `coeff_addr` ≥ TAPS is impossible by width.
  - A write is visible to weighting from the next cycle. A window already in the tree is unaffected.
  - Writes are allowed mid-stream.
- **Peak tracker.**
  - `mag` = |`dout`|, unsigned OW−1 bits.
  - A new peak requires all of: `dout_valid`, `mag` ≥ `thr`, and `mag` > the running max (strict, so ties keep the earlier peak).
  - On a new peak: max ← `mag`, `peak_idx` ← the index carried with that window, and `peak_flag` pulses in the same cycle as that `dout_valid`.
- **Precedence.**
  - `RST` overrides everything.
  - `clear` overrides `din_valid` (the sample is discarded) and in-flight valids: `dout_valid` is 0 from the next cycle until refill.
  - `coeff_we` together with `clear` performs the write.

Reset values:
- `dout` = 0, `dout_valid` = 0, `peak_flag` = 0, `peak_idx` = 0.
- Running max = 0, delay line = 0, fill counter = 0, index = 0.
- All coefficients = 00.

## Timing

- **Latency.** Sample accepted at edge n → `dout`/`dout_valid` at edge n + 1 + clog2(TAPS). There is one weighting register stage, then one register per tree level. TAPS=16 gives 5 cycles.
- **Throughput.** One sample per cycle. Back-to-back `din_valid` yields back-to-back `dout_valid` once full.
- **Valid pipeline.** A valid bit and the sample index travel alongside the data through every stage.
- **Gaps.** Gaps in `din_valid` produce matching gaps in `dout_valid`.
- **Peak outputs.** `peak_flag` and `peak_idx` are registered with `dout`; no extra cycle.
- **Clear.** Asserted at edge c: every stage's valid is 0 after edge c. The next `dout_valid` comes no earlier than TAPS accepted samples plus latency.
- **Wrap.** The index wraps to 0 after 2^IDXW−1. A peak window may carry a wrapped index; the max is not reset by wrap.

## Structure

- **Shared package `ofdm_ml_pkg`:**
  - Coefficient code constants: `ML_ZERO`, `ML_HALF`, `ML_ONE`, `ML_NEG`.
  - A `clog2` function.
  - The OW derivation.
- **Sub-module `ml_tap_weight`:** one combinational tap (code plus sample → WIDTH+1-bit product), instantiated TAPS times via generate.
- Adder tree, valid/index pipeline and peak tracker stay in `ml_corr_bank`.

## Test plan

- **Reset/fill.** Reset, then stream 15 samples of value 100 (TAPS=16, all codes 10) → no `dout_valid`. The 16th sample → `dout` = 1600 exactly 5 cycles later, with `peak_idx` = 15.
- **Codes.** taps 0–3 = 01, 10, 11, 00 (rest 00), constant input −3 → `dout` = −2 − 3 + 3 + 0 = −2.
- **Extremes.** WIDTH=17, all taps 11, input −65536 → `dout` = +1048576 with no overflow. All taps 10 → −1048576.
- **Peak.** `thr` = 500, single impulse 1000 at index 40, tap 5 code 10 → `peak_flag` once with `peak_idx` = 45. A later equal impulse → no flag. A larger one (1200) → flag.
- **Clear and precedence.** `clear` together with `din_valid` mid-stream → that sample is dropped, `dout_valid` stays low for TAPS samples, and the index restarts at 0. Coefficients are retained.
- **Live coefficient write.** Change tap 0 from 10 to 11 between samples k and k+1 → outputs up to window k use +, from window k+1 use −.
